wb_stage: RTL and testbench
===========================

Name: wb_stage

Overview:
- MEM/WB pipeline register and write-back stage; sits directly upstream of the 32-entry register file.
- Captures the MEM-stage result and aligns/extends load data.
- Selects the write-back source and drives the register file's RegWrite/Write_addr/Write_data.
- Also flags misaligned loads and counts retired instructions.

Parameters:
- bit_size, 32, datapath width; only 32 is supported (load extension assumes 32-bit words).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- stall  in  1  hold WB entry; no commit this cycle
- flush  in  1  discard the incoming MEM entry
- in_valid  in  1  MEM entry is valid
- in_reg_write  in  1  instruction writes a GPR
- in_wb_sel  in  2  00 ALU, 01 load, 10 link (PC+8), 11 reserved
- in_load_type  in  3  000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU; others treated as LW
- in_addr_lo  in  2  load byte offset (ALU address bits [1:0])
- in_dest  in  5  destination register
- in_alu_result  in  bit_size  ALU result
- in_mem_rdata  in  bit_size  raw data-memory word
- in_pc_plus8  in  bit_size  link value
- RegWrite  out  1  register-file write enable
- Write_addr  out  5  register-file write address
- Write_data  out  bit_size  register-file write data
- misalign_err  out  1  committed entry was a misaligned load
- retire_count  out  32  number of committed instructions

Behaviour:
- Reset (rst low, async): entry valid=0, all captured fields 0, retire_count=0. Outputs: RegWrite=0, Write_addr=0, Write_data=0, misalign_err=0.
- Capture, at posedge when stall=0:
  - valid <= in_valid & ~flush.
  - dest, reg_write and wb_sel are latched.
  - The selected and extended data word is latched.
  - mis <= (wb_sel==01) & misaligned.
- stall=1: entire entry holds; flush is ignored while stalled (stall has priority).
- Data select at capture:
  - ALU: in_alu_result.
  - Link: in_pc_plus8.
  - Load: extract from in_mem_rdata, little-endian.
    - LW: whole word.
    - LH/LHU: half h=addr_lo[1], bits [16h+15:16h], sign-/zero-extended.
    - LB/LBU: byte k=addr_lo, bits [8k+7:8k], sign-/zero-extended.
- Misaligned load: LW with addr_lo!=0, or LH/LHU with addr_lo[0]=1.
- Outputs (combinational from entry, gated by stall):
  - RegWrite = valid & reg_write & (dest!=0) & (wb_sel!=11) & ~mis & ~stall.
  - Write_addr = dest and Write_data = latched data, whenever valid; 0 when not valid.
  - misalign_err = valid & mis & ~stall (one-cycle pulse per committed entry).
- Commit:
  - An entry commits at the first rising edge where it is valid and stall=0; the register file samples RegWrite at that same edge.
  - Each entry commits exactly once, however long it was stalled.
- Latency: MEM inputs presented at edge N are written into the register file at edge N+1 (absent stall).
- retire_count:
  - +1 on every commit of a valid entry, including non-writing, reserved-sel and misaligned ones.
  - Wraps 0xFFFFFFFF -> 0.
  - Flushed entries are not counted.
- dest=0 with reg_write=1: no write; still retires.
- Reset mid-stall: the entry is lost, no write occurs, and the counter clears.

Decomposition:
- Shared package (mips_pkg): WB_SEL_ALU/LOAD/LINK/RSVD, LD_LW/LH/LHU/LB/LBU encodings, BIT_SIZE=32.
- One natural sub-module: load_align (combinational). Inputs: rdata, addr_lo, load_type. Outputs: data, misaligned. It is reused by later cache/LSU work.

Test Plan:
- Reset: hold rst=0 mid-traffic -> all outputs 0 and retire_count=0 immediately (asynchronous); after release, the first valid ALU entry (dest=5, 0x1234ABCD) gives RegWrite=1, Write_addr=5, Write_data=0x1234ABCD one edge later.
- Loads, with rdata=0x80FF7F01:
  - LB off 3 -> 0xFFFFFF80; LBU off 3 -> 0x00000080; LB off 2 -> 0x000000FF sign-ext -> 0xFFFFFFFF.
  - LH off 2 -> 0xFFFF80FF; LHU off 0 -> 0x00007F01; LW off 0 -> 0x80FF7F01.
- Misalign: LW off 2, or LH off 1, dest=8 -> RegWrite=0, misalign_err=1 for one cycle, retire_count+1.
- Stall: capture ALU entry dest=3, then stall=1 for 3 cycles -> RegWrite=0 throughout; on stall release RegWrite=1 for exactly one cycle and retire_count+1 (not +4). Assert flush during the stall -> entry still commits.
- Flush and r0: flush=1 with in_valid=1 -> no write, count unchanged. Link entry dest=31, pc_plus8=0x00400010 -> Write_data=0x00400010. dest=0 with reg_write=1 -> RegWrite=0, count+1.
- Counter wrap: force retire_count to 0xFFFFFFFF via 2^32 commits (or a bench backdoor), commit one entry -> 0x00000000.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS datapath: write-back source select and load types.
package mips_pkg;

    localparam int unsigned BIT_SIZE = 32;

    typedef enum logic [1:0] {
        WB_SEL_ALU  = 2'b00,
        WB_SEL_LOAD = 2'b01,
        WB_SEL_LINK = 2'b10,
        WB_SEL_RSVD = 2'b11
    } wb_sel_e;

    typedef enum logic [2:0] {
        LD_LW  = 3'b000,
        LD_LH  = 3'b001,
        LD_LHU = 3'b010,
        LD_LB  = 3'b011,
        LD_LBU = 3'b100
    } ld_type_e;

endpackage

// File: rtl/load_align.sv
// Little-endian load extraction and extension, plus natural-alignment check.
module load_align
    import mips_pkg::*;
(
    input  logic [BIT_SIZE-1:0] rdata,
    input  logic [1:0]          addr_lo,
    input  logic [2:0]          load_type,
    output logic [BIT_SIZE-1:0] data,
    output logic                misaligned
);

    logic [15:0] half;
    logic [7:0]  byte_sel;

    always_comb begin
        half     = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        byte_sel = rdata[7:0];
        case (addr_lo)
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            2'd3:    byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase
    end

    // Unlisted load types behave as LW.
    always_comb begin
        data       = rdata;
        misaligned = 1'b0;
        case (load_type)
            LD_LH: begin
                data       = {{16{half[15]}}, half};
                misaligned = addr_lo[0];
            end
            LD_LHU: begin
                data       = {16'h0000, half};
                misaligned = addr_lo[0];
            end
            LD_LB:  data = {{24{byte_sel[7]}}, byte_sel};
            LD_LBU: data = {24'h000000, byte_sel};
            default: begin
                data       = rdata;
                misaligned = (addr_lo != 2'd0);
            end
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// MEM/WB pipeline register and write-back stage feeding the register file.
module wb_stage
    import mips_pkg::*;
#(
    parameter int unsigned bit_size = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                flush,
    input  logic                in_valid,
    input  logic                in_reg_write,
    input  logic [1:0]          in_wb_sel,
    input  logic [2:0]          in_load_type,
    input  logic [1:0]          in_addr_lo,
    input  logic [4:0]          in_dest,
    input  logic [bit_size-1:0] in_alu_result,
    input  logic [bit_size-1:0] in_mem_rdata,
    input  logic [bit_size-1:0] in_pc_plus8,
    output logic                RegWrite,
    output logic [4:0]          Write_addr,
    output logic [bit_size-1:0] Write_data,
    output logic                misalign_err,
    output logic [31:0]         retire_count
);

    logic [bit_size-1:0] ld_data;
    logic                ld_mis;
    logic [bit_size-1:0] sel_data;

    logic                valid_q;
    logic                reg_write_q;
    wb_sel_e             wb_sel_q;
    logic [4:0]          dest_q;
    logic [bit_size-1:0] data_q;
    logic                mis_q;
    logic [31:0]         cnt_q;
    logic                commit;

    load_align u_load_align (
        .rdata      (in_mem_rdata),
        .addr_lo    (in_addr_lo),
        .load_type  (in_load_type),
        .data       (ld_data),
        .misaligned (ld_mis)
    );

    always_comb begin
        sel_data = in_alu_result;
        case (wb_sel_e'(in_wb_sel))
            WB_SEL_LOAD: sel_data = ld_data;
            WB_SEL_LINK: sel_data = in_pc_plus8;
            default:     sel_data = in_alu_result;
        endcase
    end

    // The entry leaving this cycle commits; stall freezes both entry and commit.
    assign commit = valid_q & ~stall;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            wb_sel_q    <= WB_SEL_ALU;
            dest_q      <= 5'd0;
            data_q      <= '0;
            mis_q       <= 1'b0;
            cnt_q       <= 32'd0;
        end else begin
            if (!stall) begin
                valid_q     <= in_valid & ~flush;
                reg_write_q <= in_reg_write;
                wb_sel_q    <= wb_sel_e'(in_wb_sel);
                dest_q      <= in_dest;
                data_q      <= sel_data;
                mis_q       <= (wb_sel_e'(in_wb_sel) == WB_SEL_LOAD) & ld_mis;
            end
            if (commit) begin
                cnt_q <= cnt_q + 32'd1;
            end
        end
    end

    assign RegWrite     = commit & reg_write_q & (dest_q != 5'd0)
                        & (wb_sel_q != WB_SEL_RSVD) & ~mis_q;
    assign Write_addr   = valid_q ? dest_q : 5'd0;
    assign Write_data   = valid_q ? data_q : '0;
    assign misalign_err = commit & mis_q;
    assign retire_count = cnt_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        in_valid;
    logic        in_reg_write;
    logic [1:0]  in_wb_sel;
    logic [2:0]  in_load_type;
    logic [1:0]  in_addr_lo;
    logic [4:0]  in_dest;
    logic [31:0] in_alu_result;
    logic [31:0] in_mem_rdata;
    logic [31:0] in_pc_plus8;
    logic        RegWrite;
    logic [4:0]  Write_addr;
    logic [31:0] Write_data;
    logic        misalign_err;
    logic [31:0] retire_count;

    int checks   = 0;
    int failures = 0;

    localparam logic [31:0] RD = 32'h80FF7F01;

    wb_stage #(.bit_size(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_reg_write  (in_reg_write),
        .in_wb_sel     (in_wb_sel),
        .in_load_type  (in_load_type),
        .in_addr_lo    (in_addr_lo),
        .in_dest       (in_dest),
        .in_alu_result (in_alu_result),
        .in_mem_rdata  (in_mem_rdata),
        .in_pc_plus8   (in_pc_plus8),
        .RegWrite      (RegWrite),
        .Write_addr    (Write_addr),
        .Write_data    (Write_data),
        .misalign_err  (misalign_err),
        .retire_count  (retire_count)
    );

    always #5 clk = ~clk;

    task automatic drv(input logic v, input logic rw, input logic [1:0] sel,
                       input logic [2:0] lt, input logic [1:0] lo, input logic [4:0] d,
                       input logic [31:0] alu, input logic [31:0] rd, input logic [31:0] pc);
        in_valid      = v;
        in_reg_write  = rw;
        in_wb_sel     = sel;
        in_load_type  = lt;
        in_addr_lo    = lo;
        in_dest       = d;
        in_alu_result = alu;
        in_mem_rdata  = rd;
        in_pc_plus8   = pc;
    endtask

    task automatic chk(input string tag, input logic rw, input logic [4:0] a,
                       input logic [31:0] d, input logic m, input logic [31:0] c);
        checks++;
        assert (RegWrite === rw) else begin
            failures++;
            $error("FAIL %s RegWrite got=%b exp=%b", tag, RegWrite, rw);
        end
        checks++;
        assert (Write_addr === a) else begin
            failures++;
            $error("FAIL %s Write_addr got=%0d exp=%0d", tag, Write_addr, a);
        end
        checks++;
        assert (Write_data === d) else begin
            failures++;
            $error("FAIL %s Write_data got=%h exp=%h", tag, Write_data, d);
        end
        checks++;
        assert (misalign_err === m) else begin
            failures++;
            $error("FAIL %s misalign_err got=%b exp=%b", tag, misalign_err, m);
        end
        checks++;
        assert (retire_count === c) else begin
            failures++;
            $error("FAIL %s retire_count got=%h exp=%h", tag, retire_count, c);
        end
    endtask

    initial begin
        rst   = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        drv(1'b0, 1'b0, 2'b00, 3'b000, 2'd0, 5'd0, 32'h0, 32'h0, 32'h0);
        repeat (2) @(negedge clk);
        chk("reset", 1'b0, 5'd0, 32'h0, 1'b0, 32'd0);

        rst = 1'b1;
        drv(1'b1, 1'b1, 2'b00, 3'b000, 2'd0, 5'd5, 32'h1234ABCD, 32'h0, 32'h0);
        @(negedge clk); chk("alu_first", 1'b1, 5'd5, 32'h1234ABCD, 1'b0, 32'd0);

        // Loads from 0x80FF7F01
        drv(1'b1, 1'b1, 2'b01, 3'b011, 2'd3, 5'd8, 32'h0, RD, 32'h0);
        @(negedge clk); chk("lb_off3", 1'b1, 5'd8, 32'hFFFFFF80, 1'b0, 32'd1);
        drv(1'b1, 1'b1, 2'b01, 3'b100, 2'd3, 5'd8, 32'h0, RD, 32'h0);
        @(negedge clk); chk("lbu_off3", 1'b1, 5'd8, 32'h00000080, 1'b0, 32'd2);
        drv(1'b1, 1'b1, 2'b01, 3'b011, 2'd2, 5'd8, 32'h0, RD, 32'h0);
        @(negedge clk); chk("lb_off2", 1'b1, 5'd8, 32'hFFFFFFFF, 1'b0, 32'd3);
        drv(1'b1, 1'b1, 2'b01, 3'b001, 2'd2, 5'd8, 32'h0, RD, 32'h0);
        @(negedge clk); chk("lh_off2", 1'b1, 5'd8, 32'hFFFF80FF, 1'b0, 32'd4);
        drv(1'b1, 1'b1, 2'b01, 3'b010, 2'd0, 5'd8, 32'h0, RD, 32'h0);
        @(negedge clk); chk("lhu_off0", 1'b1, 5'd8, 32'h00007F01, 1'b0, 32'd5);
        drv(1'b1, 1'b1, 2'b01, 3'b000, 2'd0, 5'd8, 32'h0, RD, 32'h0);
        @(negedge clk); chk("lw_off0", 1'b1, 5'd8, 32'h80FF7F01, 1'b0, 32'd6);

        // Misaligned loads retire without writing
        drv(1'b1, 1'b1, 2'b01, 3'b000, 2'd2, 5'd8, 32'h0, RD, 32'h0);
        @(negedge clk); chk("mis_lw2", 1'b0, 5'd8, 32'h80FF7F01, 1'b1, 32'd7);
        drv(1'b1, 1'b1, 2'b01, 3'b001, 2'd1, 5'd8, 32'h0, RD, 32'h0);
        @(negedge clk); chk("mis_lh1", 1'b0, 5'd8, 32'h00007F01, 1'b1, 32'd8);
        drv(1'b0, 1'b0, 2'b00, 3'b000, 2'd0, 5'd0, 32'h0, 32'h0, 32'h0);
        @(negedge clk); chk("mis_done", 1'b0, 5'd0, 32'h0, 1'b0, 32'd9);

        // Stall for three edges with flush and a competing entry asserted
        drv(1'b1, 1'b1, 2'b00, 3'b000, 2'd0, 5'd3, 32'hCAFEF00D, 32'h0, 32'h0);
        @(negedge clk);
        stall = 1'b1;
        flush = 1'b1;
        drv(1'b1, 1'b1, 2'b00, 3'b000, 2'd0, 5'd9, 32'h55555555, 32'h0, 32'h0);
        #1 chk("stall0", 1'b0, 5'd3, 32'hCAFEF00D, 1'b0, 32'd9);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); chk("stall_hold", 1'b0, 5'd3, 32'hCAFEF00D, 1'b0, 32'd9);
        end
        stall = 1'b0;
        flush = 1'b0;
        drv(1'b0, 1'b0, 2'b00, 3'b000, 2'd0, 5'd0, 32'h0, 32'h0, 32'h0);
        #1 chk("stall_release", 1'b1, 5'd3, 32'hCAFEF00D, 1'b0, 32'd9);
        @(negedge clk); chk("stall_once", 1'b0, 5'd0, 32'h0, 1'b0, 32'd10);

        // Flushed entry is dropped and not counted
        flush = 1'b1;
        drv(1'b1, 1'b1, 2'b00, 3'b000, 2'd0, 5'd4, 32'h66666666, 32'h0, 32'h0);
        @(negedge clk); chk("flush", 1'b0, 5'd0, 32'h0, 1'b0, 32'd10);
        flush = 1'b0;

        drv(1'b1, 1'b1, 2'b10, 3'b000, 2'd0, 5'd31, 32'h77777777, 32'h0, 32'h00400010);
        @(negedge clk); chk("link", 1'b1, 5'd31, 32'h00400010, 1'b0, 32'd10);
        drv(1'b1, 1'b1, 2'b00, 3'b000, 2'd0, 5'd0, 32'h11111111, 32'h0, 32'h0);
        @(negedge clk); chk("r0", 1'b0, 5'd0, 32'h11111111, 1'b0, 32'd11);
        drv(1'b1, 1'b1, 2'b11, 3'b000, 2'd0, 5'd7, 32'h0, 32'h0, 32'h0);
        @(negedge clk); chk("rsvd_sel", 1'b0, 5'd7, 32'h0, 1'b0, 32'd12);

        // Asynchronous reset while a stalled entry is pending
        drv(1'b1, 1'b1, 2'b00, 3'b000, 2'd0, 5'd6, 32'h33333333, 32'h0, 32'h0);
        @(negedge clk); chk("pre_rst", 1'b1, 5'd6, 32'h33333333, 1'b0, 32'd13);
        stall = 1'b1;
        #2 rst = 1'b0;
        #1 chk("async_rst", 1'b0, 5'd0, 32'h0, 1'b0, 32'd0);
        @(negedge clk);
        rst   = 1'b1;
        stall = 1'b0;
        drv(1'b0, 1'b0, 2'b00, 3'b000, 2'd0, 5'd0, 32'h0, 32'h0, 32'h0);
        @(negedge clk); chk("rst_lost", 1'b0, 5'd0, 32'h0, 1'b0, 32'd0);

        drv(1'b1, 1'b1, 2'b00, 3'b000, 2'd0, 5'd5, 32'h1234ABCD, 32'h0, 32'h0);
        @(negedge clk); chk("alu_after_rst", 1'b1, 5'd5, 32'h1234ABCD, 1'b0, 32'd0);
        drv(1'b0, 1'b0, 2'b00, 3'b000, 2'd0, 5'd0, 32'h0, 32'h0, 32'h0);
        @(negedge clk); chk("idle", 1'b0, 5'd0, 32'h0, 1'b0, 32'd1);

        // Counter wrap via backdoor preload
        force dut.cnt_q = 32'hFFFFFFFF;
        #1 release dut.cnt_q;
        chk("preload", 1'b0, 5'd0, 32'h0, 1'b0, 32'hFFFFFFFF);
        drv(1'b1, 1'b1, 2'b00, 3'b000, 2'd0, 5'd2, 32'h44444444, 32'h0, 32'h0);
        @(negedge clk); chk("wrap_commit", 1'b1, 5'd2, 32'h44444444, 1'b0, 32'hFFFFFFFF);
        drv(1'b0, 1'b0, 2'b00, 3'b000, 2'd0, 5'd0, 32'h0, 32'h0, 32'h0);
        @(negedge clk); chk("wrap", 1'b0, 5'd0, 32'h0, 1'b0, 32'h00000000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
